alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Issue-side controller for the 8-bit nRISC ALU. It accepts one instruction plus two operands over a valid/ready request port and decodes the instruction into ALUcontrol, shamt and the operand buses.
- It waits a fixed number of cycles for the ALU, captures ALUout and zero, and returns them over a valid/ready response port.
- It sits between the decode/register-read stage and the ALU, replacing direct combinational drive of the ALU inputs.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- ALU_LATENCY, 1, cycles from ALU inputs becoming valid to ALUout being sampled. Legal range 1..7; use 2 for a registered-output ALU.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_instr  input  8  [7:5] ALU op, [4:2] shamt, [1] swap operands, [0] chain (use previous result as a).
- req_a  input  WIDTH  operand a.
- req_b  input  WIDTH  operand b.
- alu_control  output  3  drives ALU ALUcontrol.
- alu_a  output  WIDTH  drives ALU a.
- alu_b  output  WIDTH  drives ALU b.
- alu_shamt  output  3  drives ALU shamt.
- alu_out  input  WIDTH  ALU ALUout.
- alu_zero  input  1  ALU zero.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  WIDTH  captured ALUout.
- rsp_zero  output  1  captured zero flag.
- rsp_op  output  3  op that produced rsp_data.
- busy  output  1  state != IDLE.
- op_count  output  8  completed-operation counter.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset:
  - Synchronous, active-high. Next state is IDLE.
  - Cleared to 0: alu_control, alu_a, alu_b, alu_shamt, rsp_valid, rsp_data, rsp_zero, rsp_op, op_count, the chain register and the latency counter.
  - req_ready is 1 in the first cycle after reset deasserts.
  - Reset in any state aborts the operation in flight: no capture, no op_count increment, chain register cleared.
- IDLE:
  - req_ready = 1.
  - On req_valid at edge N: register the decoded fields and go to EXEC; the latency counter loads ALU_LATENCY-1.
  - alu_control = instr[7:5]; alu_shamt = instr[4:2].
  - Operand a = chain register if instr[0], else req_a.
  - If instr[1]: alu_a = req_b and alu_b = operand a. Otherwise alu_a = operand a and alu_b = req_b.
  - If the chain bit is used before any capture, operand a = 0.
- EXEC:
  - req_ready = 0. alu_* outputs hold stable.
  - The counter decrements each cycle.
  - On the edge where the counter is 0:
    - Capture alu_out into rsp_data, alu_zero into rsp_zero and alu_control into rsp_op.
    - Copy alu_out into the chain register.
    - op_count increments, wrapping 255 -> 0.
    - rsp_valid is set and the state goes to RESP.
  - With ALU_LATENCY=1, rsp_valid rises after edge N+1. In general it rises after edge N+ALU_LATENCY.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_zero and rsp_op are stable until the handshake.
  - On rsp_ready: rsp_valid clears on that edge and the state returns to IDLE.
  - req_ready = 0 throughout; req_valid is ignored.
- Throughput: one op per ALU_LATENCY+2 cycles when rsp_ready is held at 1.
- alu_* outputs keep their last values in IDLE; they never toggle without an accept.
- busy = 1 in EXEC and RESP.
- rsp_data and rsp_zero are WIDTH-exact copies; the sequencer performs no arithmetic.

Test Plan:
- Bench ALU model: 000 add, 001 sub, zero = (out == 0). ALU_LATENCY = 1 unless stated.
1. Reset, then req_instr=000_000_00, a=2, b=2:
   - alu_control=0, alu_a=2, alu_b=2 one cycle after accept.
   - rsp_valid rises after accept+1 edge with rsp_data=4, rsp_zero=0, op_count=1.
2. req_instr=001_000_00, a=2, b=2 -> rsp_data=0, rsp_zero=1, rsp_op=1, op_count=2.
3. Chain: after result 4, req_instr=000_000_01, a=9, b=3 -> alu_a=4, rsp_data=7.
4. Swap and shamt: req_instr=001_101_10, a=2, b=5 -> alu_a=5, alu_b=2, alu_shamt=5, rsp_data=3.
5. Backpressure: rsp_ready=0 for 5 cycles while req_valid pulses:
   - rsp_valid stays 1, rsp_data is unchanged and req_ready=0.
   - No extra op is accepted and op_count is unchanged.
6. ALU_LATENCY=3, reset asserted in the second EXEC cycle:
   - Next cycle: IDLE, req_ready=1, rsp_valid=0, op_count=0.
   - Separately, 256 completed ops wrap op_count to 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the nRISC ALU: registers decoded operands,
// waits a fixed latency, then returns the captured result over valid/ready.
module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_instr,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

  state_e           state_q, state_d;
  logic [2:0]       ctl_q, ctl_d;
  logic [2:0]       shamt_q, shamt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] chain_q, chain_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [7:0]       op_count_q, op_count_d;
  logic [WIDTH-1:0] opa;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ctl_q       <= '0;
      shamt_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      chain_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_op_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      shamt_q     <= shamt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_op_q    <= rsp_op_d;
      op_count_q  <= op_count_d;
    end
  end

  // chain_q is zero until the first capture, so early chains read 0
  assign opa = req_instr[0] ? chain_q : req_a;

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    shamt_d     = shamt_q;
    a_d         = a_q;
    b_d         = b_q;
    chain_d     = chain_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_op_d    = rsp_op_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = EXEC;
          ctl_d   = req_instr[7:5];
          shamt_d = req_instr[4:2];
          cnt_d   = CNT_INIT;
          if (req_instr[1]) begin
            a_d = req_b;
            b_d = opa;
          end else begin
            a_d = opa;
            b_d = req_b;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_out;
          rsp_zero_d  = alu_zero;
          rsp_op_d    = ctl_q;
          chain_d     = alu_out;
          op_count_d  = op_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    alu_control = ctl_q;
    alu_shamt   = shamt_q;
    alu_a       = a_q;
    alu_b       = b_q;
    rsp_valid   = rsp_valid_q;
    rsp_data    = rsp_data_q;
    rsp_zero    = rsp_zero_q;
    rsp_op      = rsp_op_q;
    op_count    = op_count_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: latency-1 and latency-3 instances,
// each driving a small add/sub ALU model.
module tb_alu_sequencer;

  logic       clock;
  int         errors;
  int         checks;

  logic       reset1, req_valid1, req_ready1, alu_zero1;
  logic       rsp_valid1, rsp_ready1, rsp_zero1, busy1;
  logic [7:0] req_instr1, req_a1, req_b1, alu_a1, alu_b1, alu_out1;
  logic [7:0] rsp_data1, op_count1;
  logic [2:0] alu_control1, alu_shamt1, rsp_op1;

  logic       reset2, req_valid2, req_ready2, alu_zero2;
  logic       rsp_valid2, rsp_ready2, rsp_zero2, busy2;
  logic [7:0] req_instr2, req_a2, req_b2, alu_a2, alu_b2, alu_out2;
  logic [7:0] rsp_data2, op_count2;
  logic [2:0] alu_control2, alu_shamt2, rsp_op2;

  alu_sequencer #(.WIDTH(8), .ALU_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset1),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_instr(req_instr1), .req_a(req_a1), .req_b(req_b1),
    .alu_control(alu_control1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_shamt(alu_shamt1), .alu_out(alu_out1), .alu_zero(alu_zero1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_zero(rsp_zero1), .rsp_op(rsp_op1),
    .busy(busy1), .op_count(op_count1)
  );

  alu_sequencer #(.WIDTH(8), .ALU_LATENCY(3)) dut2 (
    .clock(clock), .reset(reset2),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_instr(req_instr2), .req_a(req_a2), .req_b(req_b2),
    .alu_control(alu_control2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_shamt(alu_shamt2), .alu_out(alu_out2), .alu_zero(alu_zero2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_data(rsp_data2), .rsp_zero(rsp_zero2), .rsp_op(rsp_op2),
    .busy(busy2), .op_count(op_count2)
  );

  // ALU model: 001 subtracts, every other op adds
  always_comb begin
    alu_out1  = (alu_control1 == 3'd1) ? alu_a1 - alu_b1 : alu_a1 + alu_b1;
    alu_zero1 = (alu_out1 == 8'd0);
    alu_out2  = (alu_control2 == 3'd1) ? alu_a2 - alu_b2 : alu_a2 + alu_b2;
    alu_zero2 = (alu_out2 == 8'd0);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue1(input logic [7:0] ins, input logic [7:0] a,
                        input logic [7:0] b);
    int n;
    n = 0;
    while (req_ready1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("issue1_ready", 32'(req_ready1), 32'd1);
    req_instr1 = ins;
    req_a1     = a;
    req_b1     = b;
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
  endtask

  task automatic issue2(input logic [7:0] ins, input logic [7:0] a,
                        input logic [7:0] b);
    int n;
    n = 0;
    while (req_ready2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("issue2_ready", 32'(req_ready2), 32'd1);
    req_instr2 = ins;
    req_a2     = a;
    req_b2     = b;
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
  endtask

  task automatic drain1();
    rsp_ready1 = 1'b1;
    tick();
    rsp_ready1 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset1 = 1'b1; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
    req_instr1 = '0; req_a1 = '0; req_b1 = '0;
    reset2 = 1'b1; req_valid2 = 1'b0; rsp_ready2 = 1'b0;
    req_instr2 = '0; req_a2 = '0; req_b2 = '0;
    tick();
    tick();
    reset1 = 1'b0;
    reset2 = 1'b0;
    tick();

    chk("rst_ready", 32'(req_ready1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_data", 32'(rsp_data1), 32'd0);
    chk("rst_count", 32'(op_count1), 32'd0);
    chk("rst_alu", {alu_control1, alu_shamt1, alu_a1, alu_b1}, 32'd0);
    chk("rst2_alu", {alu_control2, alu_shamt2, alu_a2, alu_b2}, 32'd0);

    // add 2+2
    issue1(8'b000_000_00, 8'd2, 8'd2);
    chk("t1_ctl", 32'(alu_control1), 32'd0);
    chk("t1_a", 32'(alu_a1), 32'd2);
    chk("t1_b", 32'(alu_b1), 32'd2);
    chk("t1_busy", 32'(busy1), 32'd1);
    chk("t1_noready", 32'(req_ready1), 32'd0);
    chk("t1_notyet", 32'(rsp_valid1), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid1), 32'd1);
    chk("t1_data", 32'(rsp_data1), 32'd4);
    chk("t1_zero", 32'(rsp_zero1), 32'd0);
    chk("t1_count", 32'(op_count1), 32'd1);
    drain1();
    chk("t1_idle", 32'(rsp_valid1), 32'd0);

    // sub 2-2
    issue1(8'b001_000_00, 8'd2, 8'd2);
    tick();
    chk("t2_data", 32'(rsp_data1), 32'd0);
    chk("t2_zero", 32'(rsp_zero1), 32'd1);
    chk("t2_op", 32'(rsp_op1), 32'd1);
    chk("t2_count", 32'(op_count1), 32'd2);
    drain1();

    // chain off a fresh result of 4
    issue1(8'b000_000_00, 8'd2, 8'd2);
    tick();
    chk("t3_pre", 32'(rsp_data1), 32'd4);
    drain1();
    issue1(8'b000_000_01, 8'd9, 8'd3);
    chk("t3_a", 32'(alu_a1), 32'd4);
    chk("t3_b", 32'(alu_b1), 32'd3);
    tick();
    chk("t3_data", 32'(rsp_data1), 32'd7);
    chk("t3_count", 32'(op_count1), 32'd4);
    drain1();

    // swap with shamt
    issue1(8'b001_101_10, 8'd2, 8'd5);
    chk("t4_a", 32'(alu_a1), 32'd5);
    chk("t4_b", 32'(alu_b1), 32'd2);
    chk("t4_shamt", 32'(alu_shamt1), 32'd5);
    chk("t4_ctl", 32'(alu_control1), 32'd1);
    tick();
    chk("t4_data", 32'(rsp_data1), 32'd3);

    // backpressure with request pulses
    for (int i = 0; i < 5; i++) begin
      req_valid1 = (i % 2 == 0);
      req_instr1 = 8'b000_000_00;
      req_a1 = 8'd100;
      req_b1 = 8'd100;
      tick();
      chk("t5_valid", 32'(rsp_valid1), 32'd1);
      chk("t5_data", 32'(rsp_data1), 32'd3);
      chk("t5_ready", 32'(req_ready1), 32'd0);
      chk("t5_count", 32'(op_count1), 32'd5);
    end
    req_valid1 = 1'b0;
    chk("t5_hold_a", 32'(alu_a1), 32'd5);
    drain1();
    chk("t5_released", 32'(rsp_valid1), 32'd0);
    chk("t5_idle_ready", 32'(req_ready1), 32'd1);
    tick();
    chk("t5_idle_hold", {alu_control1, alu_shamt1, alu_a1, alu_b1},
        {8'd0, 3'd1, 3'd5, 8'd5, 8'd2});

    // latency 3: first a clean op, then reset mid-EXEC
    issue2(8'b000_000_00, 8'd3, 8'd4);
    tick();
    chk("l3_wait1", 32'(rsp_valid2), 32'd0);
    tick();
    chk("l3_wait2", 32'(rsp_valid2), 32'd0);
    tick();
    chk("l3_valid", 32'(rsp_valid2), 32'd1);
    chk("l3_data", 32'(rsp_data2), 32'd7);
    chk("l3_zero", 32'(rsp_zero2), 32'd0);
    chk("l3_op", 32'(rsp_op2), 32'd0);
    chk("l3_count", 32'(op_count2), 32'd1);
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    issue2(8'b000_000_01, 8'd0, 8'd1);
    chk("l3_chain_a", 32'(alu_a2), 32'd7);
    tick();
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_ready", 32'(req_ready2), 32'd1);
    chk("abort_valid", 32'(rsp_valid2), 32'd0);
    chk("abort_count", 32'(op_count2), 32'd0);
    chk("abort_data", 32'(rsp_data2), 32'd0);
    tick();
    chk("abort_stay", 32'(rsp_valid2), 32'd0);
    issue2(8'b000_000_01, 8'd5, 8'd5);
    chk("abort_chain0", 32'(alu_a2), 32'd0);
    tick();
    tick();
    tick();
    chk("abort_next", 32'(rsp_data2), 32'd5);
    chk("abort_next_cnt", 32'(op_count2), 32'd1);

    // op_count wrap over 256 ops
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    chk("wrap_start", 32'(op_count1), 32'd0);
    rsp_ready1 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      issue1(8'b000_000_00, 8'(i), 8'd1);
      tick();
      tick();
    end
    chk("wrap_255", 32'(op_count1), 32'd255);
    chk("wrap_data", 32'(rsp_data1), 32'd255);
    issue1(8'b000_000_00, 8'd255, 8'd1);
    tick();
    chk("wrap_zero", 32'(rsp_zero1), 32'd1);
    chk("wrap_0", 32'(op_count1), 32'd0);
    tick();
    rsp_ready1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
